// File: rtl/adc_scan_sequencer.sv
// Scans N_CH channels through serial ADCs and publishes every frame atomically on coordinates_o.
// Optional per-channel averaging of 2^AVG_LOG2 conversions is enabled by defining ADC_AVG_EN.
module adc_scan_sequencer #(
   parameter int unsigned N_CH       = 3,
   parameter int unsigned SAMPLE_W   = 8,
   parameter int unsigned CH_PER_CS  = 2,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned LEAD_BITS  = 1,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned AVG_LOG2   = 2,
   localparam int unsigned N_CS      = (N_CH + CH_PER_CS - 1) / CH_PER_CS,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       ena_i,
   input  logic                       mode_cont_i,
   input  logic                       data_chl_i,
   output logic                       sclk_o,
   output logic [N_CS-1:0]            cs_o,
   output logic [CH_W-1:0]            chl_sel_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [N_CH*SAMPLE_W-1:0]   coordinates_o
);

   localparam int unsigned B       = LEAD_BITS + SAMPLE_W;
   localparam int unsigned BIT_W   = $clog2(B + 1);
   localparam int unsigned CNT_MAX = (SETTLE_CYC > CLK_DIV) ? SETTLE_CYC : CLK_DIV;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned OUT_W   = N_CH * SAMPLE_W;
`ifdef ADC_AVG_EN
   localparam int unsigned AVG_SH  = AVG_LOG2;
`else
   localparam int unsigned AVG_SH  = 0;
`endif
   localparam int unsigned ACC_W   = SAMPLE_W + AVG_SH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_CONV,
      S_STORE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic [OUT_W-1:0]    shadow_q, shadow_d;
   logic [OUT_W-1:0]    coords_q, coords_d;
   logic                sclk_q, sclk_d;
   logic [N_CS-1:0]     cs_q, cs_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ACC_W-1:0]    sum;
   logic                last_rep;
   int unsigned         cs_idx;

`ifdef ADC_AVG_EN
   localparam int unsigned REP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         ch_q     <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         shadow_q <= '0;
         coords_q <= '0;
         sclk_q   <= 1'b0;
         cs_q     <= '1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef ADC_AVG_EN
         acc_q    <= '0;
         rep_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         shadow_q <= shadow_d;
         coords_q <= coords_d;
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef ADC_AVG_EN
         acc_q    <= acc_d;
         rep_q    <= rep_d;
`endif
      end
   end

   // Next-state logic; sclk/cs are computed for the coming cycle so they leave the flops glitch-free
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      shadow_d = shadow_q;
      coords_d = coords_q;
      sclk_d   = sclk_q;
      cs_d     = cs_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cs_idx   = 32'(ch_q) / CH_PER_CS;
`ifdef ADC_AVG_EN
      acc_d    = acc_q;
      rep_d    = rep_q;
      sum      = acc_q + ACC_W'(shift_q);
      last_rep = (rep_q == REP_W'((1 << AVG_LOG2) - 1));
`else
      sum      = ACC_W'(shift_q);
      last_rep = 1'b1;
`endif

      case (state_q)
         S_IDLE: begin
            if (ena_i) begin
               state_d = S_SETUP;
               ch_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end

         S_SETUP: begin
            cs_d   = '1;
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               state_d = S_CONV;
               cnt_d   = '0;
               bit_d   = '0;
               cs_d    = ~(N_CS'(1) << cs_idx);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_CONV: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  if (bit_q >= BIT_W'(LEAD_BITS)) begin
                     shift_d = SAMPLE_W'({shift_q, data_chl_i});
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == BIT_W'(B - 1)) begin
                     state_d = S_STORE;
                     cs_d    = '1;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_STORE: begin
            cnt_d = '0;
            if (last_rep) begin
               shadow_d[32'(ch_q)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(sum >> AVG_SH);
`ifdef ADC_AVG_EN
               acc_d = '0;
               rep_d = '0;
`endif
               if (ch_q == CH_W'(N_CH - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SETUP;
                  ch_d    = ch_q + CH_W'(1);
               end
            end else begin
`ifdef ADC_AVG_EN
               acc_d = sum;
               rep_d = rep_q + REP_W'(1);
`endif
               state_d = S_SETUP;
            end
         end

         S_DONE: begin
            coords_d = shadow_q;
            done_d   = 1'b1;
            ch_d     = '0;
            cnt_d    = '0;
            if (mode_cont_i && ena_i) begin
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign sclk_o        = sclk_q;
   assign cs_o          = cs_q;
   assign chl_sel_o     = ch_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign coordinates_o = coords_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed + randomized bench for adc_scan_sequencer with a serial ADC model and a frame-level reference.
// Honours ADC_AVG_EN to match the DUT build.
module tb_adc_scan_sequencer;

   localparam int unsigned N_CH       = 3;
   localparam int unsigned SAMPLE_W   = 8;
   localparam int unsigned CH_PER_CS  = 2;
   localparam int unsigned CLK_DIV    = 2;
   localparam int unsigned LEAD_BITS  = 1;
   localparam int unsigned SETTLE_CYC = 2;
   localparam int unsigned AVG_LOG2   = 2;
   localparam int unsigned N_CS       = (N_CH + CH_PER_CS - 1) / CH_PER_CS;
   localparam int unsigned CH_W       = $clog2(N_CH);
   localparam int unsigned CW         = N_CH * SAMPLE_W;
   localparam int unsigned B          = LEAD_BITS + SAMPLE_W;
`ifdef ADC_AVG_EN
   localparam int unsigned NAVG       = 1 << AVG_LOG2;
`else
   localparam int unsigned NAVG       = 1;
`endif
   localparam int unsigned T_CH       = SETTLE_CYC + 2 * CLK_DIV * B + 1;
   localparam int unsigned LAT        = N_CH * NAVG * T_CH + 1;
   localparam int unsigned LIMIT      = LAT + 50;

   logic            clk = 1'b0;
   logic            rst, ena, mode_cont, data_chl;
   logic            sclk, busy, done;
   logic [N_CS-1:0] cs;
   logic [CH_W-1:0] chl_sel;
   logic [CW-1:0]   coordinates;

   adc_scan_sequencer #(
      .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .CH_PER_CS(CH_PER_CS), .CLK_DIV(CLK_DIV),
      .LEAD_BITS(LEAD_BITS), .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .mode_cont_i(mode_cont), .data_chl_i(data_chl),
      .sclk_o(sclk), .cs_o(cs), .chl_sel_o(chl_sel), .busy_o(busy), .done_o(done),
      .coordinates_o(coordinates)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [SAMPLE_W-1:0] vals [N_CH][NAVG];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each channel's word is the truncated mean of its conversions
   function automatic logic [CW-1:0] model();
      logic [CW-1:0] r = '0;
      for (int c = 0; c < N_CH; c++) begin
         int unsigned s = 0;
         for (int k = 0; k < NAVG; k++) s += vals[c][k];
         r[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(s / NAVG);
      end
      return r;
   endfunction

   task automatic set_const(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
      for (int k = 0; k < NAVG; k++) begin
         vals[0][k] = v0; vals[1][k] = v1; vals[2][k] = v2;
      end
   endtask

   task automatic set_rand();
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < NAVG; k++) vals[c][k] = SAMPLE_W'($urandom);
   endtask

   // Counts clk edges until done is seen high (sampled on falling edges), bounded by LIMIT
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (!done && n < LIMIT);
   endtask

   task automatic run_single(input string tag);
      int n;
      logic [CW-1:0] exp;
      exp = model();
      @(negedge clk) ena = 1'b1;
      @(posedge clk);
      @(negedge clk) ena = 1'b0;
      wait_done(n);
      chk({tag, "_latency"}, 64'(n), 64'(LAT));
      chk({tag, "_coords"}, 64'(coordinates), 64'(exp));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_busy_after"}, 64'(busy), 64'(0));
   endtask

   // ADC model and bus monitor, evaluated just after each rising edge
   logic [N_CS-1:0] prev_cs = '1;
   logic            prev_sclk = 1'b0;
   int fall_cnt = 0, rises = 0, conv_idx = 0, cur_ch = 0, cur_k = 0;
   int total_rises = 0, done_cnt = 0;
   bit both_low = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         conv_idx = 0;
         fall_cnt = 0;
         data_chl = 1'b0;
      end else begin
         if (prev_cs == '1 && cs != '1) begin
            int unsigned exp_ch;
            logic [N_CS-1:0] ecs;
            exp_ch = (conv_idx / NAVG) % N_CH;
            ecs    = ~(N_CS'(1) << (exp_ch / CH_PER_CS));
            chk("chl_sel_at_cs", 64'(chl_sel), 64'(exp_ch));
            chk("cs_owner", 64'(cs), 64'(ecs));
            cur_ch   = int'(chl_sel);
            cur_k    = conv_idx % NAVG;
            conv_idx++;
            fall_cnt = 0;
            rises    = 0;
         end
         if (prev_sclk && !sclk) fall_cnt++;
         if (!prev_sclk && sclk) begin
            rises++;
            total_rises++;
         end
         if (prev_cs != '1 && cs == '1) chk("sclk_rises", 64'(rises), 64'(B));
         if ($countones(~cs) > 1) both_low = 1'b1;
         if (done) done_cnt++;
         if (cs != '1 && fall_cnt >= 1 && fall_cnt <= SAMPLE_W && cur_ch < N_CH)
            data_chl = vals[cur_ch][cur_k][SAMPLE_W - fall_cnt];
         else
            data_chl = 1'b0;
      end
      prev_cs   = cs;
      prev_sclk = sclk;
   end

   initial begin
      int n, r0, d0;
      logic [CW-1:0] exp;
      rst = 1'b1; ena = 1'b0; mode_cont = 1'b0; data_chl = 1'b0;
      set_const(8'h00, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", 64'(cs), 64'(2'b11));
      chk("rst_sclk", 64'(sclk), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_coords", 64'(coordinates), 64'(24'h0));
      chk("rst_chl_sel", 64'(chl_sel), 64'(0));
      rst = 1'b0;

      // All-ones data, single-shot frame, then the bus must stay quiet
      set_const(8'hFF, 8'hFF, 8'hFF);
      run_single("ones");
      chk("ones_value", 64'(coordinates), 64'(24'hFFFFFF));
      r0 = total_rises;
      repeat (60) @(negedge clk);
      chk("ones_no_sclk", 64'(total_rises - r0), 64'(0));
      chk("ones_idle_busy", 64'(busy), 64'(0));

      set_const(8'hA5, 8'h3C, 8'h81);
      run_single("pattern");
      chk("pattern_value", 64'(coordinates), 64'(24'h813CA5));

      for (int i = 0; i < 3; i++) begin
         set_rand();
         run_single("random");
      end

      // Continuous mode: three back-to-back frames, ena dropped inside the third
      mode_cont = 1'b1;
      set_rand();
      exp = model();
      @(negedge clk) ena = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_done(n);
      chk("cont_f1_latency", 64'(n), 64'(LAT));
      chk("cont_f1_coords", 64'(coordinates), 64'(exp));
      set_rand();
      exp = model();
      wait_done(n);
      chk("cont_f2_period", 64'(n), 64'(LAT));
      chk("cont_f2_coords", 64'(coordinates), 64'(exp));
      set_rand();
      exp = model();
      repeat (10) @(negedge clk);
      ena = 1'b0;
      wait_done(n);
      chk("cont_f3_period", 64'(n + 10), 64'(LAT));
      chk("cont_f3_coords", 64'(coordinates), 64'(exp));
      @(negedge clk);
      chk("cont_busy_after", 64'(busy), 64'(0));
      d0 = done_cnt;
      repeat (LAT + 20) @(negedge clk);
      chk("cont_stopped", 64'(done_cnt - d0), 64'(0));
      chk("cont_held", 64'(coordinates), 64'(exp));
      mode_cont = 1'b0;

      // Reset in the middle of a frame
      set_rand();
      @(negedge clk) ena = 1'b1;
      @(posedge clk);
      @(negedge clk) ena = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      d0 = done_cnt;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cs", 64'(cs), 64'(2'b11));
      chk("abort_sclk", 64'(sclk), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_coords", 64'(coordinates), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
      set_rand();
      run_single("after_abort");

`ifdef ADC_AVG_EN
      for (int k = 0; k < NAVG; k++) begin
         vals[0][k] = 8'h10 + 8'(k);
         vals[1][k] = 8'h20;
         vals[2][k] = 8'h20;
      end
      run_single("avg");
      chk("avg_value", 64'(coordinates), 64'(24'h202011));
`endif

      chk("cs_exclusive", 64'(both_low), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
